alu_functional_unit: RTL and testbench

//  Integer execution unit directly downstream of the reservation station. Accepts issued ops
//  (ROB index, full instr, two resolved operands), queues them in a 2-entry skid FIFO, executes

---
 rtl/alu_functional_unit.sv | 125 ++++++++++++
 tb/tb_alu_functional_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_functional_unit.sv
// Integer execution unit: 2-entry skid FIFO -> registered EX -> WB register broadcasting on
// one CDB slot under req/grant. Drives the reservation station's busy input.
module alu_functional_unit #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned SKID_D    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [ROB_IDX_W-1:0] in_rob_index,
    input  logic [15:0]          in_instr,
    input  logic [DATA_W-1:0]    in_val1,
    input  logic [DATA_W-1:0]    in_val2,
    output logic                 busy,
    output logic                 cdb_req,
    output logic [ROB_IDX_W-1:0] cdb_rob_index,
    output logic [DATA_W-1:0]    cdb_result,
    input  logic                 cdb_grant,
    output logic                 overflow
);

    // Skid FIFO storage; only the opcode field of the instruction is needed downstream.
    logic [ROB_IDX_W-1:0] fifo_rob [2];
    logic [3:0]           fifo_op  [2];
    logic [DATA_W-1:0]    fifo_v1  [2];
    logic [DATA_W-1:0]    fifo_v2  [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           count;

    logic                 ex_valid;
    logic [ROB_IDX_W-1:0] ex_rob;
    logic [3:0]           ex_op;
    logic [DATA_W-1:0]    ex_v1, ex_v2, ex_result;

    logic                 wb_valid;
    logic [ROB_IDX_W-1:0] wb_rob;
    logic [DATA_W-1:0]    wb_result;

    logic wb_fire, ex_adv, deq, enq, drop, fifo_full;
    logic unused_instr;

    assign unused_instr = ^in_instr[11:0];

    always_comb begin
        wb_fire   = wb_valid & cdb_grant;
        ex_adv    = ex_valid & (~wb_valid | wb_fire);
        fifo_full = (count == 2'(SKID_D));
        deq       = (count != 2'd0) & (~ex_valid | ex_adv);
        enq       = in_valid & (~fifo_full | deq);
        drop      = in_valid & fifo_full & ~deq;
    end

    always_comb begin
        ex_result = '0;
        case (ex_op)
            4'd0:    ex_result = ex_v1 + ex_v2;
            4'd1:    ex_result = ex_v1 - ex_v2;
            4'd2:    ex_result = ex_v1 & ex_v2;
            4'd3:    ex_result = ex_v1 | ex_v2;
            4'd4:    ex_result = ex_v1 ^ ex_v2;
            4'd5:    ex_result = ex_v1 << ex_v2[3:0];
            4'd6:    ex_result = ex_v1 >> ex_v2[3:0];
            4'd7:    ex_result = ex_v1 * ex_v2;
            default: ex_result = '0;
        endcase
    end

    // Control state; flush squashes every stage but leaves the sticky overflow alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            ex_valid  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rob    <= '0;
            wb_result <= '0;
            overflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            ex_valid <= 1'b0;
            wb_valid <= 1'b0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, enq} - {1'b0, deq};
            if (deq) begin
                ex_valid <= 1'b1;
            end else if (ex_adv) begin
                ex_valid <= 1'b0;
            end
            if (~wb_valid | wb_fire) wb_valid <= ex_valid;
            if (ex_adv) begin
                wb_rob    <= ex_rob;
                wb_result <= ex_result;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            fifo_rob[wr_ptr] <= in_rob_index;
            fifo_op[wr_ptr]  <= in_instr[15:12];
            fifo_v1[wr_ptr]  <= in_val1;
            fifo_v2[wr_ptr]  <= in_val2;
        end
        if (deq && !flush) begin
            ex_rob <= fifo_rob[rd_ptr];
            ex_op  <= fifo_op[rd_ptr];
            ex_v1  <= fifo_v1[rd_ptr];
            ex_v2  <= fifo_v2[rd_ptr];
        end
    end

    assign busy          = (count != 2'd0);
    assign cdb_req       = wb_valid;
    assign cdb_rob_index = wb_rob;
    assign cdb_result    = wb_result;

endmodule

// File: tb/tb_alu_functional_unit.sv
// Directed bench for alu_functional_unit: latency, op decode, stall/drain, overflow, flush, reset.
module tb_alu_functional_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, cdb_grant;
    logic [3:0]  in_rob_index;
    logic [15:0] in_instr, in_val1, in_val2;
    logic        busy, cdb_req, overflow;
    logic [3:0]  cdb_rob_index;
    logic [15:0] cdb_result;

    int total = 0;
    int bad   = 0;

    alu_functional_unit dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_rob_index (in_rob_index),
        .in_instr     (in_instr),
        .in_val1      (in_val1),
        .in_val2      (in_val2),
        .busy         (busy),
        .cdb_req      (cdb_req),
        .cdb_rob_index(cdb_rob_index),
        .cdb_result   (cdb_result),
        .cdb_grant    (cdb_grant),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rob, input logic [3:0] op,
                         input logic [15:0] v1, input logic [15:0] v2);
        in_valid     = 1'b1;
        in_rob_index = rob;
        in_instr     = {op, 12'h000};
        in_val1      = v1;
        in_val2      = v2;
    endtask

    task automatic wb_chk(input string tag, input logic [3:0] rob, input logic [15:0] res);
        chk({tag, ".req"}, {31'd0, cdb_req}, 32'd1);
        chk({tag, ".idx"}, {28'd0, cdb_rob_index}, {28'd0, rob});
        chk({tag, ".res"}, {16'd0, cdb_result}, {16'd0, res});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        in_rob_index = '0; in_instr = '0; in_val1 = '0; in_val2 = '0;
        #1;
        chk("rst.req", {31'd0, cdb_req}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.idx", {28'd0, cdb_rob_index}, 32'd0);
        chk("rst.res", {16'd0, cdb_result}, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        tick();
        rst = 1'b0;
        cdb_grant = 1'b1;

        // Minimum latency: add 5+7 -> 12 on rob 3
        drive(4'd3, 4'd0, 16'd5, 16'd7);
        tick();
        in_valid = 1'b0;
        chk("lat.e0.req", {31'd0, cdb_req}, 32'd0);
        chk("lat.e0.busy", {31'd0, busy}, 32'd1);
        tick();
        chk("lat.e1.req", {31'd0, cdb_req}, 32'd0);
        chk("lat.e1.busy", {31'd0, busy}, 32'd0);
        tick();
        wb_chk("lat.e2", 4'd3, 16'd12);
        chk("lat.e2.busy", {31'd0, busy}, 32'd0);
        tick();
        chk("lat.e3.req", {31'd0, cdb_req}, 32'd0);

        // Back-to-back with grant held: sub, shl, mul
        drive(4'd1, 4'd1, 16'd1, 16'd2);      tick();
        drive(4'd2, 4'd5, 16'd1, 16'd4);      tick();
        drive(4'd5, 4'd7, 16'h0100, 16'h0100); tick();
        in_valid = 1'b0;
        wb_chk("b2b.sub", 4'd1, 16'hFFFF);
        tick();
        wb_chk("b2b.shl", 4'd2, 16'h0010);
        tick();
        wb_chk("b2b.mul", 4'd5, 16'h0000);
        tick();
        chk("b2b.end.req", {31'd0, cdb_req}, 32'd0);

        // Stall: four ops with grant low, then an overflowing fifth
        cdb_grant = 1'b0;
        drive(4'd6, 4'd2, 16'h0F0F, 16'h00FF); tick();
        drive(4'd7, 4'd3, 16'hF000, 16'h000F); tick();
        drive(4'd8, 4'd4, 16'hFFFF, 16'h1234); tick();
        wb_chk("stall.e3", 4'd6, 16'h000F);
        chk("stall.e3.busy", {31'd0, busy}, 32'd1);
        drive(4'd9, 4'd6, 16'h8000, 16'd15);   tick();
        wb_chk("stall.e4", 4'd6, 16'h000F);
        chk("stall.e4.busy", {31'd0, busy}, 32'd1);
        chk("stall.e4.ovf", {31'd0, overflow}, 32'd0);
        drive(4'd10, 4'd0, 16'd1, 16'd1);      tick();
        in_valid = 1'b0;
        chk("ovf.set", {31'd0, overflow}, 32'd1);
        wb_chk("ovf.hold", 4'd6, 16'h000F);
        tick();
        wb_chk("ovf.hold2", 4'd6, 16'h000F);
        cdb_grant = 1'b1;
        tick();
        wb_chk("drain.or", 4'd7, 16'hF00F);
        chk("drain.or.busy", {31'd0, busy}, 32'd1);
        tick();
        wb_chk("drain.xor", 4'd8, 16'hEDCB);
        chk("drain.xor.busy", {31'd0, busy}, 32'd0);
        tick();
        wb_chk("drain.shr", 4'd9, 16'h0001);
        tick();
        chk("drain.end.req", {31'd0, cdb_req}, 32'd0);
        chk("drain.end.ovf", {31'd0, overflow}, 32'd1);

        // Flush with ops in FIFO, EX and WB; grant and in_valid on the flush edge ignored
        cdb_grant = 1'b0;
        drive(4'd1, 4'd0, 16'd2, 16'd3); tick();
        drive(4'd2, 4'd0, 16'd2, 16'd3); tick();
        drive(4'd3, 4'd0, 16'd2, 16'd3); tick();
        wb_chk("fl.pre", 4'd1, 16'd5);
        chk("fl.pre.busy", {31'd0, busy}, 32'd1);
        drive(4'd4, 4'd0, 16'd2, 16'd3);
        flush = 1'b1;
        cdb_grant = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.req", {31'd0, cdb_req}, 32'd0);
        chk("fl.busy", {31'd0, busy}, 32'd0);
        chk("fl.ovf", {31'd0, overflow}, 32'd1);
        tick();
        tick();
        chk("fl.later.req", {31'd0, cdb_req}, 32'd0);

        // Async reset mid-stall; unused opcode 9 yields 0
        cdb_grant = 1'b0;
        drive(4'd11, 4'd9, 16'd5, 16'd5); tick();
        drive(4'd12, 4'd0, 16'd5, 16'd5); tick();
        drive(4'd14, 4'd0, 16'd5, 16'd5); tick();
        in_valid = 1'b0;
        wb_chk("op9", 4'd11, 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.req", {31'd0, cdb_req}, 32'd0);
        chk("arst.busy", {31'd0, busy}, 32'd0);
        chk("arst.idx", {28'd0, cdb_rob_index}, 32'd0);
        chk("arst.res", {16'd0, cdb_result}, 32'd0);
        chk("arst.ovf", {31'd0, overflow}, 32'd0);
        tick();
        rst = 1'b0;
        cdb_grant = 1'b1;
        tick();
        chk("arst.after.req", {31'd0, cdb_req}, 32'd0);
        drive(4'd13, 4'd0, 16'h7FFF, 16'd1); tick();
        in_valid = 1'b0;
        tick();
        tick();
        wb_chk("resume", 4'd13, 16'h8000);
        tick();
        chk("resume.end.req", {31'd0, cdb_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
